seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Parametrised multiplexed 7-segment scan controller, successor to the fixed 6-digit BCD scan driver. It drives `DIGITS` common-anode digits and adds per-digit decimal points, leading-zero blanking, per-digit blink, and 16-level brightness PWM. It also inserts a dead-time blank between digits to suppress ghosting, and takes double-buffered display updates through a load strobe that only takes effect at a frame boundary. It sits between the application display registers and the board `sel`/`seg` pins.

## Interface
- `DIGITS`, 6: number of digits, legal range 1..8.
- `SLOT_CYCLES`, 50000: clocks per digit slot (1 ms at 50 MHz). Must be ≥ `BLANK_CYCLES`+16.
- `BLANK_CYCLES`, 500: dead-time clocks at the start of each slot.
- `BLINK_FRAMES`, 250: frames per blink half-period. Must be ≥ 1.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_bcd` in 4*DIGITS: digit nibbles; digit i is `[4i+3:4i]`. Captured on `load`.
- `dp` in DIGITS: decimal point enable per digit. Captured on `load`.
- `blink_en` in DIGITS: blink enable per digit. Captured on `load`.
- `load` in 1: single-cycle strobe that captures the three inputs above into staging.
- `lz_blank` in 1: leading-zero blanking enable. Sampled live.
- `bright` in 4: brightness level, 0 = dimmest, 15 = full. Sampled live.
- `sel` out DIGITS: digit select, active low; bit i selects digit i.
- `seg` out 8: segments, active low, ordered `.gfedcba`.
- `pending` out 1: high while staged data is waiting to be applied.
- `frame_tick` out 1: one-cycle pulse at the start of each frame.

## Operation
- **Scan counter.**
  - The counter holds a pair (idx, cnt). cnt runs 0..SLOT_CYCLES-1. When cnt wraps, idx advances 0..DIGITS-1, then returns to 0.
  - One frame is DIGITS slots.
- **Slot windows.** STEP is the constant (SLOT_CYCLES-BLANK_CYCLES)/16, using integer division.
  - Dead time, cnt < BLANK_CYCLES: the digit is off.
  - On window, BLANK_CYCLES ≤ cnt < BLANK_CYCLES+(bright+1)*STEP: the digit is on.
  - Any other cnt: the digit is off.
- **Off state.** `sel` = all ones and `seg` = 8'hFF.
- **On state.** `sel` drives bit idx low and all other bits high. `seg` is the glyph for the nibble, with bit 7 = ~dp[idx].
- **Glyph table, hex:**
  - 0..9: C0 F9 A4 B0 99 92 82 F8 80 90.
  - A..F: 88 83 C6 A1 86 8E.
- **Leading-zero blanking.** Applies only when `lz_blank`=1.
  - Digit i ≥ 1 is blanked if its nibble and every higher digit's nibble are all 0.
  - Digit 0 is never blanked.
  - For a blanked digit, the glyph bits [6:0] are all 1. `dp` still shows and `sel` is still driven.
- **Blink.**
  - A frame counter counts completed frames. At BLINK_FRAMES it wraps to 0 and toggles `blink_phase`.
  - When `blink_phase`=1, digits with `blink_en` set are fully off, including `dp`.
- **Double buffer.**
  - `load`=1 writes the inputs into staging and sets `pending`. If a load arrives while pending, the newest load wins.
  - Apply edge: the edge on which the counter is (DIGITS-1, SLOT_CYCLES-1). On this edge staging is copied to active and `pending` clears. If `load`=1 on that same edge, the old staging goes to active, the new data goes to staging, and `pending` stays 1.
  - Display decode always uses the active copy.
- **Reset values.**
  - `sel` = all ones, `seg` = 8'hFF, `pending` = 0, `frame_tick` = 0.
  - Staging, active, `blink_phase`, frame counter, idx and cnt are all 0.
  - Reset asserted mid-frame returns to these values immediately, with no glitch on the outputs beyond the reset values.

## Timing
- `sel`, `seg` and `frame_tick` are registered. Each is computed from the (idx, cnt) value sampled at an edge and appears after that edge, i.e. one-cycle latency.
- `frame_tick` is 1 for exactly one cycle following each edge that samples (0, 0). This includes the first edge after reset release.
- A `load` is visible on `pending` the cycle after its edge. Its data first drives the outputs at slot (0, 0) of the next frame. Worst-case apply latency is DIGITS*SLOT_CYCLES cycles.
- `bright` and `lz_blank` changes take effect on the next output register update.
- All outputs are glitch-free because they come directly from flops.

## Test plan
Unless stated otherwise, all scenarios use DIGITS=4, SLOT_CYCLES=40, BLANK_CYCLES=8, BLINK_FRAMES=2, so STEP=2.

1. **Reset.** Hold `rst_n`=0, then release.
   - While in reset: `sel`=4'hF, `seg`=8'hFF, `pending`=0.
   - After release: `frame_tick` pulses on the first cycle, and the first frame shows "0000".
2. **Load and apply.** Load `data_bcd`=16'h12AF, dp=4'b0010, bright=15, mid-frame.
   - `pending`=1 until the apply edge.
   - Next frame: digit0 shows seg=8E with sel=1110, digit1 shows seg=0x88&0x7F=08, digit2 shows A4, digit3 shows F9.
   - Each digit is on for cycles 8..39 of its slot.
3. **Brightness.** Set bright=0.
   - The digit is on only at cnt 8..9 of each slot; otherwise sel=F and seg=FF.
   - Sweep bright and check on-length = 2*(bright+1).
4. **Leading-zero blanking.** lz_blank=1, data 16'h0030.
   - Digits 3 and 2 show seg=FF with sel driven.
   - Digit1 shows B0; digit0 shows C0.
   - With data 16'h0000, only digit0 shows C0.
5. **Blink.** blink_en=4'b0001.
   - Digit0 is on in frames 0-1, fully off in frames 2-3, and on again in frames 4-5.
   - Other digits are unaffected.
6. **Load collisions.** Load A, then load B before the apply edge, then assert `load`=C exactly on the apply edge.
   - The frame after that edge shows B.
   - `pending` stays 1, and C appears in the following frame.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with dimming, blink and double-buffered updates
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   data_bcd, dp,
//   blink_en, load     : display contents, captured into staging on load
//   lz_blank, bright   : leading-zero blanking and brightness, sampled live
//   sel, seg           : active-low digit select and segments (.gfedcba)
//   pending            : staged data is waiting for the frame boundary
//   frame_tick         : one-cycle pulse at the start of each frame

module seg_scan_ctrl #(
    parameter int DIGITS       = 6,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data_bcd,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  load,
    input  logic                  lz_blank,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            seg,
    output logic                  pending,
    output logic                  frame_tick
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int STEP  = (SLOT_CYCLES - BLANK_CYCLES) / 16;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    cnt;
    logic [FRM_W-1:0]    frame_cnt;
    logic                blink_phase;

    logic [4*DIGITS-1:0] stg_data, act_data;
    logic [DIGITS-1:0]   stg_dp, act_dp;
    logic [DIGITS-1:0]   stg_blink, act_blink;

    logic                apply_edge;
    logic [31:0]         cnt_ext;
    logic [31:0]         win_end;
    logic                in_window;

    logic [3:0]          nib;
    logic                cur_dp;
    logic                cur_blink;
    logic                cur_blank;
    logic                zero_run;
    logic                digit_on;
    logic [DIGITS-1:0]   sel_next;
    logic [7:0]          seg_next;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = 7'h08;
            4'hB:    glyph = 7'h03;
            4'hC:    glyph = 7'h46;
            4'hD:    glyph = 7'h21;
            4'hE:    glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // Last clock of the last slot: the only point where staged data may go live.
    assign apply_edge = (idx == IDX_LAST) && (cnt == CNT_LAST);

    // On-window length scales with brightness; done in 32 bits so the end
    // point may equal SLOT_CYCLES without overflowing the counter width.
    assign cnt_ext   = 32'(cnt);
    assign win_end   = 32'(BLANK_CYCLES) + (32'(bright) + 32'd1) * 32'(STEP);
    assign in_window = (cnt_ext >= 32'(BLANK_CYCLES)) && (cnt_ext < win_end);

    // Walk digits from the most significant down; zero_run stays set while
    // every nibble seen so far (this one and all higher) is zero.
    always_comb begin
        nib       = 4'h0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_blank = 1'b0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (act_data[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                nib       = act_data[4*i +: 4];
                cur_dp    = act_dp[i];
                cur_blink = act_blink[i];
                cur_blank = lz_blank && zero_run && (i != 0);
            end
        end
    end

    assign digit_on = in_window && !(blink_phase && cur_blink);

    always_comb begin
        sel_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_on && (idx == IDX_W'(i))) begin
                sel_next[i] = 1'b0;
            end
        end
        seg_next = 8'hFF;
        if (digit_on) begin
            seg_next = {~cur_dp, cur_blank ? 7'h7F : glyph(nib)};
        end
    end

    // Scan position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered pin drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= '1;
            seg        <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            sel        <= sel_next;
            seg        <= seg_next;
            frame_tick <= (idx == '0) && (cnt == '0);
        end
    end

    // Double buffer: staging always takes a load; active only changes at the
    // frame boundary, and a load on that same edge stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_data  <= '0;
            stg_dp    <= '0;
            stg_blink <= '0;
            act_data  <= '0;
            act_dp    <= '0;
            act_blink <= '0;
            pending   <= 1'b0;
        end else begin
            if (load) begin
                stg_data  <= data_bcd;
                stg_dp    <= dp;
                stg_blink <= blink_en;
            end
            if (apply_edge) begin
                act_data  <= stg_data;
                act_dp    <= stg_dp;
                act_blink <= stg_blink;
                pending   <= load;
            end else if (load) begin
                pending   <= 1'b1;
            end
        end
    end

    // Blink timing counts completed frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (apply_edge) begin
            if (frame_cnt == FRM_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt   <= frame_cnt + FRM_W'(1);
            end
        end
    end

endmodule
